// File: rtl/wb_sram_slave.sv
`default_nettype none
// ============================================================================
// wb_sram_slave : Wishbone classic-cycle slave driving an asynchronous 8-bit
//                 SRAM with programmable read/write access lengths.
// Rev 1.0
// ============================================================================
module wb_sram_slave #(
   parameter int ADDR_W  = 16,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [7:0]        wb_dat_i,
   output logic [7:0]        wb_dat_o,
   input  logic              wb_we_i,
   input  logic              wb_stb_i,
   input  logic              wb_cyc_i,
   output logic              wb_ack_o,
   output logic [ADDR_W-1:0] sram_a_o,
   output logic [7:0]        sram_dq_o,
   input  logic [7:0]        sram_dq_i,
   output logic              sram_dq_oe_o,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o
);

   localparam int RD_EFF  = (RD_WAIT < 1) ? 1 : RD_WAIT;
   localparam int WR_EFF  = (WR_WAIT < 1) ? 1 : WR_WAIT;
   localparam int MAX_EFF = (RD_EFF > WR_EFF) ? RD_EFF : WR_EFF;
   localparam int CNT_W   = $clog2(MAX_EFF + 1);

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_EFF);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_EFF);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_ACCESS  = 3'd2,
      ST_ACK     = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic               ack_q, ack_d;
   logic [7:0]         dat_q, dat_d;
   logic [ADDR_W-1:0]  a_q, a_d;
   logic [7:0]         dq_q, dq_d;
   logic               dq_oe_q, dq_oe_d;
   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_ONE;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
         dat_q   <= 8'h00;
         a_q     <= '0;
         dq_q    <= 8'h00;
         dq_oe_q <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         a_q     <= a_d;
         dq_q    <= dq_d;
         dq_oe_q <= dq_oe_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
      end
   end

   // Strobe registers carry the values for the state being entered, so every
   // branch sets them for state_d rather than for state_q.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      dat_d   = dat_q;
      a_d     = a_q;
      dq_d    = dq_q;
      ack_d   = 1'b0;
      dq_oe_d = 1'b0;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               state_d = ST_SETUP;
               a_d     = wb_adr_i;
               dq_d    = wb_dat_i;
               we_d    = wb_we_i;
               ce_n_d  = 1'b0;
               oe_n_d  = wb_we_i;
               dq_oe_d = wb_we_i;
            end
         end

         ST_SETUP: begin
            if (!wb_cyc_i) begin
               state_d = ST_RECOVER;
            end else begin
               state_d = ST_ACCESS;
               cnt_d   = we_q ? WR_LOAD : RD_LOAD;
               ce_n_d  = 1'b0;
               oe_n_d  = we_q;
               we_n_d  = !we_q;
               dq_oe_d = we_q;
            end
         end

         ST_ACCESS: begin
            if (!wb_cyc_i) begin
               state_d = ST_RECOVER;
            end else if (cnt_q <= CNT_ONE) begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
               ce_n_d  = 1'b0;
               dq_oe_d = we_q;
               if (!we_q) begin
                  dat_d = sram_dq_i;
               end
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
               ce_n_d  = 1'b0;
               oe_n_d  = we_q;
               we_n_d  = !we_q;
               dq_oe_d = we_q;
            end
         end

         ST_ACK: begin
            state_d = ST_RECOVER;
         end

         ST_RECOVER: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign wb_dat_o     = dat_q;
   assign wb_ack_o     = ack_q;
   assign sram_a_o     = a_q;
   assign sram_dq_o    = dq_q;
   assign sram_dq_oe_o = dq_oe_q;
   assign sram_ce_n_o  = ce_n_q;
   assign sram_oe_n_o  = oe_n_q;
   assign sram_we_n_o  = we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_slave.sv
`default_nettype none
// ============================================================================
// tb_wb_sram_slave : directed bench for wb_sram_slave (main instance with
//                    RD_WAIT=2/WR_WAIT=3, second instance at minimum waits).
// Rev 1.0
// ============================================================================
module tb_wb_sram_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   logic [15:0] adr;
   logic [7:0]  dat_i, dat_o, dq_o, dq_i;
   logic        we, stb, cyc, ack, dq_oe, ce_n, oe_n, we_n;
   logic [15:0] a;

   logic [15:0] m_adr, m_a;
   logic [7:0]  m_dat_i, m_dat_o, m_dq_o, m_dq_i;
   logic        m_we, m_stb, m_cyc, m_ack, m_dq_oe, m_ce_n, m_oe_n, m_we_n;

   int errors = 0;
   int checks = 0;

   function automatic logic [7:0] sram_rd(input logic [15:0] ad);
      case (ad)
         16'h1234: sram_rd = 8'hA5;
         16'h0010: sram_rd = 8'h11;
         16'h0020: sram_rd = 8'h22;
         16'h0030: sram_rd = 8'h33;
         16'h0040: sram_rd = 8'h44;
         default:  sram_rd = ad[7:0] ^ 8'h5C;
      endcase
   endfunction

   assign dq_i   = (!ce_n && !oe_n) ? sram_rd(a) : 8'hxx;
   assign m_dq_i = (!m_ce_n && !m_oe_n) ? sram_rd(m_a) : 8'hxx;

   // Write side of the SRAM model: remembers the last byte strobed in.
   logic [15:0] wr_addr = 16'h0;
   logic [7:0]  wr_data = 8'h0;
   always @(posedge clk) begin
      if (!ce_n && !we_n && dq_oe) begin
         wr_addr <= a;
         wr_data <= dq_o;
      end
   end

   int ce_falls = 0;
   always @(negedge ce_n) ce_falls++;

   wb_sram_slave #(.ADDR_W(16), .RD_WAIT(2), .WR_WAIT(3)) u_dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
      .wb_dat_o(dat_o), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc),
      .wb_ack_o(ack), .sram_a_o(a), .sram_dq_o(dq_o), .sram_dq_i(dq_i),
      .sram_dq_oe_o(dq_oe), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n),
      .sram_we_n_o(we_n)
   );

   wb_sram_slave #(.ADDR_W(16), .RD_WAIT(0), .WR_WAIT(0)) u_min (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(m_adr), .wb_dat_i(m_dat_i),
      .wb_dat_o(m_dat_o), .wb_we_i(m_we), .wb_stb_i(m_stb), .wb_cyc_i(m_cyc),
      .wb_ack_o(m_ack), .sram_a_o(m_a), .sram_dq_o(m_dq_o), .sram_dq_i(m_dq_i),
      .sram_dq_oe_o(m_dq_oe), .sram_ce_n_o(m_ce_n), .sram_oe_n_o(m_oe_n),
      .sram_we_n_o(m_we_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [43:0] got, exp;
      rst_n = 1'b0;
      adr = 16'hFFFF; dat_i = 8'hFF; we = 1'b1; stb = 1'b1; cyc = 1'b1;
      exp = {1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00};
      for (int c = 1; c <= 3; c++) begin
         tick();
         got = {ack, dat_o, a, dq_o, dq_oe, ce_n, oe_n, we_n, 2'b00};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_values c=%0d got=%h exp=%h", c, got, exp);
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0; rst_n = 1'b1;
      tick();
   endtask

   task automatic test_read();
      logic [4:0] got, exp;
      adr = 16'h1234; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         got = {ce_n, oe_n, we_n, dq_oe, ack};
         exp = {(c <= 4) ? 1'b0 : 1'b1, (c <= 3) ? 1'b0 : 1'b1, 1'b1, 1'b0, (c == 4)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL read_strobes c=%0d got=%b exp=%b", c, got, exp);
         end
         if (c == 1) begin
            checks++;
            if (a !== 16'h1234) begin
               errors++;
               $display("FAIL read_addr got=%h exp=1234", a);
            end
         end
         if (c == 4 || c == 6) begin
            checks++;
            if (dat_o !== 8'hA5) begin
               errors++;
               $display("FAIL read_data c=%0d got=%h exp=a5", c, dat_o);
            end
         end
         if (ack) begin stb = 1'b0; cyc = 1'b0; end
      end
   endtask

   task automatic test_write();
      logic [4:0] got, exp;
      adr = 16'hC000; dat_i = 8'h5A; we = 1'b1; stb = 1'b1; cyc = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         got = {ce_n, oe_n, we_n, dq_oe, ack};
         exp = {(c <= 5) ? 1'b0 : 1'b1, 1'b1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1,
                (c <= 5), (c == 5)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL write_strobes c=%0d got=%b exp=%b", c, got, exp);
         end
         if (ack) begin stb = 1'b0; cyc = 1'b0; we = 1'b0; end
      end
      checks++;
      if ({wr_addr, wr_data} !== {16'hC000, 8'h5A}) begin
         errors++;
         $display("FAIL write_mem got=%h:%h exp=c000:5a", wr_addr, wr_data);
      end
      checks++;
      if (dat_o !== 8'hA5) begin
         errors++;
         $display("FAIL write_keeps_rdata got=%h exp=a5", dat_o);
      end
   endtask

   task automatic test_back_to_back();
      int first, second, base;
      first = -1; second = -1; base = ce_falls;
      adr = 16'h0010; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (ack && first < 0) begin
            first = c;
            checks++;
            if (dat_o !== 8'h11) begin
               errors++;
               $display("FAIL b2b_data1 got=%h exp=11", dat_o);
            end
            stb = 1'b0; cyc = 1'b0;
         end else if (first > 0 && c == first + 1) begin
            adr = 16'h0020; stb = 1'b1; cyc = 1'b1;
         end else if (ack && second < 0) begin
            second = c;
            checks++;
            if (dat_o !== 8'h22) begin
               errors++;
               $display("FAIL b2b_data2 got=%h exp=22", dat_o);
            end
            stb = 1'b0; cyc = 1'b0;
         end
      end
      checks++;
      if (first !== 4) begin
         errors++;
         $display("FAIL b2b_first_ack got=%0d exp=4", first);
      end
      checks++;
      if (second - first !== 6) begin
         errors++;
         $display("FAIL b2b_spacing got=%0d exp=6", second - first);
      end
      checks++;
      if (ce_falls - base !== 2) begin
         errors++;
         $display("FAIL b2b_access_count got=%0d exp=2", ce_falls - base);
      end
   endtask

   task automatic test_abort();
      logic [4:0] got;
      adr = 16'h0030; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      tick();
      tick();
      stb = 1'b0; cyc = 1'b0;
      for (int c = 3; c <= 6; c++) begin
         tick();
         got = {ce_n, oe_n, we_n, dq_oe, ack};
         checks++;
         if (got !== 5'b11100) begin
            errors++;
            $display("FAIL abort_strobes c=%0d got=%b exp=11100", c, got);
         end
      end
      checks++;
      if (dat_o !== 8'h22) begin
         errors++;
         $display("FAIL abort_rdata got=%h exp=22", dat_o);
      end
   endtask

   task automatic test_min_wait();
      logic [4:0] got, exp;
      m_adr = 16'h0040; m_we = 1'b0; m_stb = 1'b1; m_cyc = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         got = {m_ce_n, m_oe_n, m_we_n, m_dq_oe, m_ack};
         exp = {(c <= 3) ? 1'b0 : 1'b1, (c <= 2) ? 1'b0 : 1'b1, 1'b1, 1'b0, (c == 3)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL min_strobes c=%0d got=%b exp=%b", c, got, exp);
         end
         if (c == 3) begin
            checks++;
            if (m_dat_o !== 8'h44) begin
               errors++;
               $display("FAIL min_data got=%h exp=44", m_dat_o);
            end
         end
         if (m_ack) begin m_stb = 1'b0; m_cyc = 1'b0; end
      end
   endtask

   task automatic test_reset_mid_access();
      logic [4:0] got;
      adr = 16'h0050; dat_i = 8'h77; we = 1'b1; stb = 1'b1; cyc = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      got = {ce_n, oe_n, we_n, dq_oe, ack};
      checks++;
      if (got !== 5'b11100) begin
         errors++;
         $display("FAIL rst_mid_strobes got=%b exp=11100", got);
      end
      checks++;
      if ({a, dat_o} !== 24'h0) begin
         errors++;
         $display("FAIL rst_mid_regs got=%h exp=000000", {a, dat_o});
      end
      rst_n = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_ack c=%0d got=%b exp=0", c, ack);
         end
      end
   endtask

   initial begin
      m_adr = 16'h0; m_dat_i = 8'h00; m_we = 1'b0; m_stb = 1'b0; m_cyc = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_abort();
      test_min_wait();
      test_reset_mid_access();
      checks++;
      if (m_dq_o !== 8'h00) begin
         errors++;
         $display("FAIL min_wdata got=%h exp=00", m_dq_o);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
